// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the up/down counter and its 7-segment display path.
//   SEG_TABLE  : active-low 7-segment patterns for nibbles 0-F,
//                bit 0 = segment a ... bit 6 = segment g.
//   ceil_div4  : number of hex digits needed to show a value of w bits.
// ---------------------------------------------------------------------------
package counter_pkg;

  localparam logic [0:15][6:0] SEG_TABLE = {
    7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
  };

  function automatic int ceil_div4(input int w);
    return (w + 3) / 4;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// ---------------------------------------------------------------------------
// seg7_decoder
// Combinational nibble to active-low 7-segment decode.
//   i_nibble : 4-bit value 0-F
//   o_seg    : segments {g,f,e,d,c,b,a}, low = lit
// ---------------------------------------------------------------------------
module seg7_decoder
  import counter_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_TABLE[i_nibble];

endmodule

// File: rtl/param_updown_counter.sv
// ---------------------------------------------------------------------------
// param_updown_counter
// Modulo-MODULUS up/down counter with parallel load, registered terminal-count
// pulse and a hex 7-segment view of the count.
//   i_clk    : clock, rising edge
//   i_clear  : synchronous active-high clear (highest priority)
//   i_load   : parallel load strobe, value clamped to MODULUS-1
//   i_enable : count enable
//   i_up     : 1 = count up, 0 = count down
//   i_d      : load value
//   o_q      : registered count, always < MODULUS
//   o_tc     : one-cycle pulse after each overflow/underflow event
//   o_hex    : active-low segments, digit i at o_hex[7i+6:7i]
// Build option: define COUNTER_SATURATE_EN to hold at the bound on overflow
// instead of wrapping (Tc still pulses on every overflow attempt).
// ---------------------------------------------------------------------------
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter longint unsigned  MODULUS = 256,
  localparam int              DIGITS  = ceil_div4(WIDTH)
) (
  input  logic                  i_clk,
  input  logic                  i_clear,
  input  logic                  i_enable,
  input  logic                  i_up,
  input  logic                  i_load,
  input  logic [WIDTH-1:0]      i_d,
  output logic [WIDTH-1:0]      o_q,
  output logic                  o_tc,
  output logic [7*DIGITS-1:0]   o_hex
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "param_updown_counter: WIDTH=%0d outside 1..32", WIDTH);
  end
  if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
    $fatal(1, "param_updown_counter: MODULUS=%0d outside 2..2^WIDTH", MODULUS);
  end

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 64'd1);

  logic [WIDTH-1:0] r_q;
  logic             r_tc;

  logic             w_at_max;
  logic             w_at_zero;
  logic             w_ovf;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_load_val;

  assign w_at_max  = (r_q == MAXV);
  assign w_at_zero = (r_q == '0);
  // Clear/load precedence is resolved in the register block; this only
  // looks at the enable path.
  assign w_ovf     = i_enable && ((i_up && w_at_max) || (!i_up && w_at_zero));

  // Out-of-range load values clamp to the top of the count range.
  assign w_load_val = (64'(i_d) >= MODULUS) ? MAXV : i_d;

  always_comb begin
    w_next = r_q;
    if (i_up) begin
`ifdef COUNTER_SATURATE_EN
      w_next = w_at_max ? MAXV : r_q + WIDTH'(1);
`else
      w_next = w_at_max ? '0 : r_q + WIDTH'(1);
`endif
    end else begin
`ifdef COUNTER_SATURATE_EN
      w_next = w_at_zero ? '0 : r_q - WIDTH'(1);
`else
      w_next = w_at_zero ? MAXV : r_q - WIDTH'(1);
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_q  <= '0;
      r_tc <= 1'b0;
    end else if (i_load) begin
      r_q  <= w_load_val;
      r_tc <= 1'b0;
    end else if (i_enable) begin
      r_q  <= w_next;
      r_tc <= w_ovf;
    end else begin
      r_tc <= 1'b0;
    end
  end

  assign o_q  = r_q;
  assign o_tc = r_tc;

  // Zero-extend so the top digit sees a full nibble when WIDTH % 4 != 0.
  logic [4*DIGITS-1:0] w_q_ext;
  assign w_q_ext = (4*DIGITS)'(r_q);

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    seg7_decoder u_dec (
      .i_nibble (w_q_ext[4*gi +: 4]),
      .o_seg    (o_hex[7*gi +: 7])
    );
  end

endmodule

// File: tb/tb_param_updown_counter.sv
module tb_param_updown_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // DUT A: default parameters
  logic       a_clear = 1'b1, a_load = 1'b0, a_en = 1'b0, a_up = 1'b1;
  logic [7:0] a_d = '0;
  logic [7:0] a_q;
  logic       a_tc;
  logic [13:0] a_hex;

  param_updown_counter u_a (
    .i_clk(clk), .i_clear(a_clear), .i_enable(a_en), .i_up(a_up),
    .i_load(a_load), .i_d(a_d), .o_q(a_q), .o_tc(a_tc), .o_hex(a_hex)
  );

  // DUT B: WIDTH=4, MODULUS=10
  logic       b_clear = 1'b1, b_load = 1'b0, b_en = 1'b0, b_up = 1'b1;
  logic [3:0] b_d = '0;
  logic [3:0] b_q;
  logic       b_tc;
  logic [6:0] b_hex;

  param_updown_counter #(.WIDTH(4), .MODULUS(10)) u_b (
    .i_clk(clk), .i_clear(b_clear), .i_enable(b_en), .i_up(b_up),
    .i_load(b_load), .i_d(b_d), .o_q(b_q), .o_tc(b_tc), .o_hex(b_hex)
  );

  // DUT C: WIDTH=5, MODULUS=32
  logic       c_clear = 1'b1, c_load = 1'b0, c_en = 1'b0, c_up = 1'b1;
  logic [4:0] c_d = '0;
  logic [4:0] c_q;
  logic       c_tc;
  logic [13:0] c_hex;

  param_updown_counter #(.WIDTH(5), .MODULUS(32)) u_c (
    .i_clk(clk), .i_clear(c_clear), .i_enable(c_en), .i_up(c_up),
    .i_load(c_load), .i_d(c_d), .o_q(c_q), .o_tc(c_tc), .o_hex(c_hex)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step_a(input logic c, input logic l, input logic e, input logic u, input logic [7:0] d);
    a_clear = c; a_load = l; a_en = e; a_up = u; a_d = d;
    @(posedge clk); #1;
  endtask

  task automatic step_b(input logic c, input logic l, input logic e, input logic u, input logic [3:0] d);
    b_clear = c; b_load = l; b_en = e; b_up = u; b_d = d;
    @(posedge clk); #1;
  endtask

  task automatic step_c(input logic c, input logic l, input logic e, input logic u, input logic [4:0] d);
    c_clear = c; c_load = l; c_en = e; c_up = u; c_d = d;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic       clear;
    logic       load;
    logic       en;
    logic       up;
    logic [7:0] d;
    logic [7:0] exp_q;
    logic       exp_tc;
  } vec_t;

  vec_t tbl [15];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0}; // clear
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h5A, 8'h5A, 1'b0}; // load beats enable
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h5B, 1'b0}; // up
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h5A, 1'b0}; // down, immediate
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h77, 8'h5A, 1'b0}; // hold
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b0}; // load FF
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1}; // wrap up
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h01, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b1}; // wrap down
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFE, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h33, 8'h00, 1'b0}; // clear beats load
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0}; // clear suppresses Tc
    tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b1};

    for (int i = 0; i < 15; i++) begin
      step_a(tbl[i].clear, tbl[i].load, tbl[i].en, tbl[i].up, tbl[i].d);
      check($sformatf("vecA[%0d].q", i), 64'(a_q), 64'(tbl[i].exp_q));
      check($sformatf("vecA[%0d].tc", i), 64'(a_tc), 64'(tbl[i].exp_tc));
      if (i == 0)  check("hexA_reset", 64'(a_hex), 64'({7'b1000000, 7'b1000000}));
      if (i == 12) check("hexA_FF",    64'(a_hex), 64'({7'b0001110, 7'b0001110}));
      if (i == 4)  check("hexA_5A",    64'(a_hex), 64'({7'b0010010, 7'b0001000}));
    end

    // Full up-count from clear: 0..255 then back to 0, Tc only after 255->0.
    step_a(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    check("fullA_start", 64'(a_q), 64'd0);
    for (int i = 0; i < 256; i++) begin
      step_a(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
      check($sformatf("fullA[%0d]", i), 64'({a_tc, a_q}),
            64'({(i == 255) ? 1'b1 : 1'b0, 8'((i + 1) % 256)}));
    end

    // Overflow at the top bound, repeated, then reverse.
    step_a(1'b0, 1'b1, 1'b0, 1'b0, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      step_a(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
`ifdef COUNTER_SATURATE_EN
      check($sformatf("satA_up[%0d]", i), 64'({a_tc, a_q}), 64'({1'b1, 8'hFF}));
`else
      check($sformatf("wrapA_up[%0d]", i), 64'({a_tc, a_q}),
            64'({(i == 0) ? 1'b1 : 1'b0, 8'(i)}));
`endif
    end
    step_a(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
`ifdef COUNTER_SATURATE_EN
    check("satA_down", 64'({a_tc, a_q}), 64'({1'b0, 8'hFE}));
`else
    check("wrapA_down", 64'({a_tc, a_q}), 64'({1'b0, 8'h01}));
`endif

    // MODULUS=10 on a 4-bit counter.
    step_b(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    check("B_clear", 64'({b_tc, b_q}), 64'({1'b0, 4'd0}));
    step_b(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
`ifdef COUNTER_SATURATE_EN
    check("B_under", 64'({b_tc, b_q}), 64'({1'b1, 4'd0}));
`else
    check("B_under", 64'({b_tc, b_q}), 64'({1'b1, 4'd9}));
    step_b(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    check("B_after", 64'({b_tc, b_q}), 64'({1'b0, 4'd8}));
`endif
    step_b(1'b0, 1'b1, 1'b0, 1'b0, 4'd12);
    check("B_load12", 64'({b_tc, b_q}), 64'({1'b0, 4'd9}));
    check("B_hex9", 64'(b_hex), 64'(7'b0010000));
    step_b(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
`ifdef COUNTER_SATURATE_EN
    check("B_over", 64'({b_tc, b_q}), 64'({1'b1, 4'd9}));
`else
    check("B_over", 64'({b_tc, b_q}), 64'({1'b1, 4'd0}));
`endif
    step_b(1'b0, 1'b1, 1'b0, 1'b0, 4'd7);
    check("B_load7", 64'({b_tc, b_q}), 64'({1'b0, 4'd7}));
    step_b(1'b0, 1'b1, 1'b0, 1'b0, 4'd10);
    check("B_load10", 64'(b_q), 64'd9);

    // WIDTH=5: two digits, top nibble zero-extended.
    step_c(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    check("C_hex_reset", 64'(c_hex), 64'({7'b1000000, 7'b1000000}));
    step_c(1'b0, 1'b1, 1'b0, 1'b0, 5'h1F);
    check("C_q1F", 64'(c_q), 64'h1F);
    check("C_hex1F", 64'(c_hex), 64'({7'b1111001, 7'b0001110}));
    step_c(1'b0, 1'b0, 1'b1, 1'b1, 5'd0);
`ifdef COUNTER_SATURATE_EN
    check("C_over", 64'({c_tc, c_q}), 64'({1'b1, 5'h1F}));
`else
    check("C_over", 64'({c_tc, c_q}), 64'({1'b1, 5'h00}));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/param_updown_counter.md
PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits, legal range 1..32.
REQ-002 Parameter MODULUS, default 256: count range 0..MODULUS-1, legal range 2..2^WIDTH.
REQ-003 Derived constant DIGITS = ceil(WIDTH/4): number of hex display digits.
REQ-004 Clock  input  1: single clock, all state updates on its rising edge.
REQ-005 Clear  input  1: reset, synchronous, active-high.
REQ-006 Enable  input  1: count enable.
REQ-007 Up  input  1: direction, 1 = increment, 0 = decrement.
REQ-008 Load  input  1: parallel load strobe.
REQ-009 D  input  WIDTH: parallel load value.
REQ-010 Q  output  WIDTH: registered count value.
REQ-011 Tc  output  1: registered terminal-count pulse.
REQ-012 HEX  output  7*DIGITS: active-low 7-segment patterns; digit i occupies HEX[7i+6:7i], bit 0 = segment a, bit 6 = segment g.

Function
REQ-013 Per-edge priority SHALL be Clear > Load > Enable; with none of them asserted, Q holds.
REQ-014 Load SHALL set Q = D when D < MODULUS, and Q = MODULUS-1 when D >= MODULUS.
REQ-015 With Enable=1 and Up=1, Q SHALL become Q+1, and 0 when Q = MODULUS-1.
REQ-016 With Enable=1 and Up=0, Q SHALL become Q-1, and MODULUS-1 when Q = 0.
REQ-017 An overflow event SHALL be defined as Clear=0, Load=0, Enable=1, and (Up=1 with Q=MODULUS-1, or Up=0 with Q=0).
REQ-018 Tc SHALL be 1 for exactly the one cycle following each overflow event, and 0 otherwise; back-to-back events (MODULUS=2) SHALL give Tc high on consecutive cycles.
REQ-019 Latency: Q and Tc SHALL reflect inputs one Clock edge after they are sampled.
REQ-020 HEX digit i SHALL show nibble Q[4i+3:4i] as 0-F, combinationally from Q (no added latency).
REQ-021 The top digit's nibble SHALL be zero-extended when WIDTH is not a multiple of 4.
REQ-022 Direction changes SHALL take effect on the same edge Up is sampled; no dead cycle.
REQ-023 Q SHALL never hold a value >= MODULUS under any input sequence.

Reset
REQ-024 Clear=1 at a rising edge SHALL force Q=0 and Tc=0, overriding Load and Enable.
REQ-025 Clear asserted mid-count SHALL suppress any overflow event on that edge; Tc SHALL be 0 on the following cycle.
REQ-026 After reset, HEX SHALL show "0" on every digit (7'b1000000 per digit).

Configuration
REQ-027 Macro COUNTER_SATURATE_EN, when defined, SHALL make an overflow event hold Q at its bound (MODULUS-1 counting up, 0 counting down) instead of wrapping.
REQ-028 With COUNTER_SATURATE_EN defined, Tc SHALL still pulse after each overflow event, including repeated events while held at the bound.
REQ-029 Without COUNTER_SATURATE_EN, wrap behaviour per REQ-015/016 SHALL apply; no other behaviour differs.

Structure
REQ-030 Shared package counter_pkg SHALL hold the 16-entry active-low segment table and the DIGITS ceiling-divide function.
REQ-031 The nibble-to-segment decode SHALL be a sub-module seg7_decoder, instantiated DIGITS times via generate.
REQ-032 Parameter legality (REQ-001/002) SHALL be checked at elaboration, with a fatal error when violated.

Verification
REQ-033 Default parameters, Clear 1 cycle, then Enable=1, Up=1 for 256 edges -> Q counts 0..255 then 0; Tc=1 only in the cycle after the 255->0 edge; HEX = {7'b0001110, 7'b0001110} at Q=8'hFF.
REQ-034 MODULUS=10, WIDTH=4, Up=0 from Q=0 -> Q=9, Tc pulses once; Load with D=12 -> Q=9.
REQ-035 Load=1, Enable=1, D=8'h5A on the same edge -> Q=8'h5A, no increment; Clear=1 with Load=1 -> Q=0.
REQ-036 Q=255, Enable=1, Up=1, Clear=1 on the same edge -> Q=0, Tc=0 next cycle.
REQ-037 COUNTER_SATURATE_EN defined, Q=255, Up=1 for 3 edges -> Q stays 255, Tc high 3 consecutive cycles; Up=0 -> Q=254, Tc=0.
REQ-038 WIDTH=5, Q=5'h1F -> DIGITS=2, upper digit shows "1" (7'b1111001), lower digit shows "F" (7'b0001110).
